aes_job_ctrl: RTL
=================

AES_JOB_CTRL -- requirements
Module: aes_job_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64, sets the watchdog cycle limit (used only with AES_TIMEOUT_EN).
REQ-002 eph1  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  2  per-requester job request (index 0 = enc client, 1 = dec client).
REQ-005 req_ready  out  2  one-hot acceptance pulse; the job transfers when req_valid[i] & req_ready[i].
REQ-006 req_dec  in  2  per-requester mode: 0 = encrypt, 1 = decrypt.
REQ-007 req_data  in  2x128  per-requester plaintext or ciphertext.
REQ-008 req_key_size  in  2x2  per-requester key size: 00 = 128, 01 = 192, 1x = 256.
REQ-009 resp_valid  out  2  one-hot result valid, held until the matching resp_ready is asserted.
REQ-010 resp_ready  in  2  per-requester result acceptance.
REQ-011 resp_data  out  128  result block, shared by both requesters.
REQ-012 resp_err  out  1  qualifies resp_data as aborted (timeout).
REQ-013 core_start  out  1  single-cycle launch pulse to the shared AES core.
REQ-014 core_dec, core_key_size, core_data  out  1/2/128  registered job fields, stable from LAUNCH until return to IDLE.
REQ-015 core_fin  in  1  core completion flag, level or pulse.
REQ-016 core_out  in  128  core result, valid while core_fin=1.

Function
REQ-017 FSM states: IDLE, LAUNCH, BUSY, RESP.
- IDLE -> LAUNCH on any req_valid.
- LAUNCH -> BUSY unconditionally.
- BUSY -> RESP on core_fin (or timeout).
- RESP -> IDLE on resp_ready[owner].
REQ-018 In IDLE, grant is round-robin. Pointer rr (reset 0) gives priority to requester rr. The other requester wins only if the requester at rr is not valid.
REQ-019 The grant asserts req_ready[winner] combinationally in IDLE. On that edge the job fields and owner index are latched. req_ready is 0 in all other states.
REQ-020 After each completed grant, rr = ~owner, so simultaneous requests alternate 0,1,0,1.
REQ-021 core_start = 1 exactly in LAUNCH, one cycle after acceptance.
REQ-022 In BUSY, core_fin=1 captures core_out into resp_data and sets resp_err = 0.
REQ-023 core_fin asserted in IDLE, LAUNCH or RESP is ignored.
REQ-024 In RESP, resp_valid[owner] = 1 and the other bit = 0. resp_data and resp_err are held stable until the handshake.
REQ-025 The return to IDLE occurs on the resp_ready[owner] edge. A new grant is possible in that IDLE cycle.
REQ-026 Minimum throughput: accept edge -> LAUNCH -> BUSY(>=1) -> RESP(>=1) -> IDLE. This gives 4 cycles per job plus the core latency.
REQ-027 resp_ready for a non-owner, or asserted outside RESP, has no effect.
REQ-028 Only one job is in flight. There is no queuing beyond the single latched job.

Reset
REQ-029 Asserting reset immediately sets:
- state = IDLE, rr = 0
- req_ready = 0, resp_valid = 0, core_start = 0
- resp_data = 0, resp_err = 0, core_* = 0
- the timeout counter = 0
REQ-030 Reset during BUSY or RESP discards the in-flight job without a response.
REQ-031 After reset deasserts, the first grant occurs in the first IDLE cycle with any req_valid.

Configuration
REQ-032 Macro AES_TIMEOUT_EN defined: a counter clears in LAUNCH and increments each BUSY cycle. If it reaches TIMEOUT_CYC without core_fin, the FSM enters RESP with resp_err = 1 and resp_data = 0.
REQ-033 core_fin on the same cycle as the limit takes priority over the timeout.
REQ-034 Without AES_TIMEOUT_EN: no counter is present, resp_err is tied 0, and BUSY waits indefinitely for core_fin.

Structure
REQ-035 The shared package aes_pkg holds:
- the state enum typedef
- key-size encodings (KS_128, KS_192, KS_256)
- a job struct typedef {dec, key_size[1:0], data[127:0]}
- the TIMEOUT_CYC default constant
REQ-036 One sub-module, aes_rr_arb (2-input round-robin arbiter with pointer update), is instantiated once. All registers use the codebase's asynchronous-reset flop primitive.

Verification
REQ-037 Single encrypt: req_valid=01, req_data=128'h27ECB2E3A5EE3894885B5289307400E3, key_size=10. Expect core_start one cycle after acceptance, core_data matching, and resp_valid=01 with resp_data=core_out.
REQ-038 Simultaneous requests: req_valid=11 held for 4 jobs. Expect grant order 0,1,0,1 and each resp_valid goes only to its owner.
REQ-039 Backpressure: resp_ready=0 for 10 cycles in RESP. Expect resp_valid and resp_data stable, no new req_ready, and a grant on the first IDLE cycle after release.
REQ-040 Reset asserted mid-BUSY: all outputs go 0 asynchronously and no response is issued. A new request after reset completes normally.
REQ-041 With AES_TIMEOUT_EN and TIMEOUT_CYC=8: core_fin never asserted gives RESP after 8 BUSY cycles with resp_err=1. core_fin exactly at cycle 8 gives resp_err=0.
REQ-042 Spurious core_fin pulsed in IDLE and RESP: no state change and no data corruption.

Source files
------------

// File: rtl/aes_job_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg -- shared types and constants for the AES job controller slice.
//   state_t          : controller FSM states (IDLE, LAUNCH, BUSY, RESP)
//   KS_128/192/256   : key-size encodings carried on req_key_size/core_key_size
//   job_t            : latched job fields {dec, key_size, data}
//   TIMEOUT_CYC_DEF  : default watchdog limit (used only with AES_TIMEOUT_EN)
// No ports.
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Any key_size with bit 1 set selects 256-bit keys.
    localparam logic [1:0] KS_128 = 2'b00;
    localparam logic [1:0] KS_192 = 2'b01;
    localparam logic [1:0] KS_256 = 2'b10;

    typedef struct packed {
        logic         dec;
        logic [1:0]   key_size;
        logic [127:0] data;
    } job_t;

    localparam int unsigned TIMEOUT_CYC_DEF = 64;

endpackage

// File: rtl/aes_job_ctrl_if.sv
// -----------------------------------------------------------------------------
// aes_job_ctrl_if -- request/response/core signal bundle of aes_job_ctrl.
//   req_valid/req_ready/req_dec/req_data/req_key_size : two requester ports
//   resp_valid/resp_ready/resp_data/resp_err          : shared result port
//   core_start/core_dec/core_key_size/core_data       : launch to AES core
//   core_fin/core_out                                 : AES core completion
// Modports: slave = controller side, master = requesters + core side.
// -----------------------------------------------------------------------------
interface aes_job_ctrl_if;

    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_dec;
    logic [1:0][127:0] req_data;
    logic [1:0][1:0]   req_key_size;

    logic [1:0]        resp_valid;
    logic [1:0]        resp_ready;
    logic [127:0]      resp_data;
    logic              resp_err;

    logic              core_start;
    logic              core_dec;
    logic [1:0]        core_key_size;
    logic [127:0]      core_data;
    logic              core_fin;
    logic [127:0]      core_out;

    modport slave (
        input  req_valid, req_dec, req_data, req_key_size, resp_ready,
               core_fin, core_out,
        output req_ready, resp_valid, resp_data, resp_err,
               core_start, core_dec, core_key_size, core_data
    );

    modport master (
        output req_valid, req_dec, req_data, req_key_size, resp_ready,
               core_fin, core_out,
        input  req_ready, resp_valid, resp_data, resp_err,
               core_start, core_dec, core_key_size, core_data
    );

endinterface

// File: rtl/aes_job_ctrl_rr_arb.sv
// -----------------------------------------------------------------------------
// aes_rr_arb -- 2-input round-robin arbiter with pointer update.
//   eph1  : clock (rising edge)
//   reset : asynchronous active-high reset (pointer -> 0)
//   en    : arbitration enabled (controller idle)
//   valid : per-requester request
//   grant : one-hot combinational grant; a grant is also the acceptance
// The pointer moves to the loser after every grant, so two permanently
// requesting clients alternate.
// -----------------------------------------------------------------------------
module aes_rr_arb (
    input  logic       eph1,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic rr;

    always_comb begin
        grant = '0;
        if (en) begin
            if (valid[rr]) begin
                grant[rr] = 1'b1;
            end else if (valid[~rr]) begin
                grant[~rr] = 1'b1;
            end
        end
    end

    // rr = ~owner; owner index is grant[1] for a one-hot grant.
    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) begin
            rr <= 1'b0;
        end else if (|grant) begin
            rr <= ~grant[1];
        end
    end

endmodule

// File: rtl/aes_job_ctrl.sv
// -----------------------------------------------------------------------------
// aes_job_ctrl -- single-job controller sharing one AES core between an
// encrypt client (index 0) and a decrypt client (index 1).
//   eph1  : clock, all state updates on rising edge
//   reset : asynchronous active-high reset, discards any in-flight job
//   bus   : aes_job_ctrl_if.slave (request, response and core signals)
// Parameter TIMEOUT_CYC: watchdog limit in BUSY cycles.
// Optional macro AES_TIMEOUT_EN: enables the BUSY watchdog; on expiry the job
// is answered with resp_err = 1 and resp_data = 0. Without it resp_err is 0
// and BUSY waits for core_fin indefinitely.
// -----------------------------------------------------------------------------
module aes_job_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic           eph1,
    input  logic           reset,
    aes_job_ctrl_if.slave  bus
);

    state_t       state;
    state_t       state_nxt;
    logic [1:0]   grant;
    logic         accept;
    logic         win;
    job_t         job_in;
    job_t         job_q;
    logic         owner_q;
    logic [127:0] resp_data_q;
    logic         fin_busy;
    logic         timeout;

    // Grant is blanked while reset is high so req_ready drops immediately.
    aes_rr_arb u_arb (
        .eph1  (eph1),
        .reset (reset),
        .en    ((state == ST_IDLE) && !reset),
        .valid (bus.req_valid),
        .grant (grant)
    );

    assign accept   = |grant;
    assign win      = grant[1];
    assign fin_busy = (state == ST_BUSY) && bus.core_fin;

    always_comb begin
        job_in          = '0;
        job_in.dec      = bus.req_dec[win];
        job_in.key_size = bus.req_key_size[win];
        job_in.data     = bus.req_data[win];
    end

    // State register
    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (accept) state_nxt = ST_LAUNCH;
            ST_LAUNCH: state_nxt = ST_BUSY;
            ST_BUSY:   if (bus.core_fin || timeout) state_nxt = ST_RESP;
            ST_RESP:   if (bus.resp_ready[owner_q]) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.req_ready  = grant;
        bus.core_start = (state == ST_LAUNCH);
        bus.resp_valid = '0;
        if (state == ST_RESP) begin
            bus.resp_valid[owner_q] = 1'b1;
        end
    end

    // Job latch on acceptance; held until the next acceptance.
    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) begin
            job_q   <= '0;
            owner_q <= 1'b0;
        end else if (accept) begin
            job_q   <= job_in;
            owner_q <= win;
        end
    end

    // Result capture; core_fin outside BUSY is ignored.
    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) begin
            resp_data_q <= '0;
        end else if (fin_busy) begin
            resp_data_q <= bus.core_out;
        end else if (timeout) begin
            resp_data_q <= '0;
        end
    end

    assign bus.core_dec      = job_q.dec;
    assign bus.core_key_size = job_q.key_size;
    assign bus.core_data     = job_q.data;
    assign bus.resp_data     = resp_data_q;

`ifdef AES_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;
    logic          resp_err_q;

    // cnt holds the number of BUSY cycles already completed, so the limit
    // is hit during the TIMEOUT_CYC-th BUSY cycle; core_fin wins that cycle.
    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == ST_LAUNCH) begin
            cnt <= '0;
        end else if (state == ST_BUSY) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign timeout = (state == ST_BUSY) && !bus.core_fin
                     && (cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) begin
            resp_err_q <= 1'b0;
        end else if (fin_busy) begin
            resp_err_q <= 1'b0;
        end else if (timeout) begin
            resp_err_q <= 1'b1;
        end
    end

    assign bus.resp_err = resp_err_q;
`else
    logic unused_timeout_cyc;

    assign timeout            = 1'b0;
    assign bus.resp_err       = 1'b0;
    assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
`endif

endmodule
